eop_timed_detect: RTL

EOP_TIMED_DETECT -- requirements
Module: eop_timed_detect

---
 rtl/eop_timed_detect.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/eop_timed_detect.sv
// USB full/low-speed end-of-packet detector: synchronizes D+/D-, times SE0 and
// trailing J periods, and reports completed EOPs, malformed EOPs and bus reset.
module eop_timed_detect #(
  parameter int SYNC_STAGES  = 2,
  parameter int SE0_MIN      = 8,
  parameter int J_MIN        = 8,
  parameter int RESET_CYCLES = 240
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_plus,
  input  logic       d_minus,
  output logic [1:0] line_state,
  output logic       se0,
  output logic       eop,
  output logic       eop_err,
  output logic       usb_reset
);

  localparam int CNT_W = $clog2(RESET_CYCLES + 1);
  localparam logic [CNT_W-1:0] SE0_MIN_C   = CNT_W'(SE0_MIN);
  localparam logic [CNT_W-1:0] RESET_C     = CNT_W'(RESET_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [1:0]       LS_SE0      = 2'b00;
  localparam logic [1:0]       LS_J        = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    SE0_CNT,
    J_CNT
  } state_e;

  logic [SYNC_STAGES-1:0] dp_sync_q, dp_sync_d;
  logic [SYNC_STAGES-1:0] dm_sync_q, dm_sync_d;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   eop_q, eop_d;
  logic                   eop_err_q, eop_err_d;
  logic                   usb_reset_q, usb_reset_d;
  logic                   line_j;

  assign line_state = {dm_sync_q[SYNC_STAGES-1], dp_sync_q[SYNC_STAGES-1]};
  assign se0        = (line_state == LS_SE0);
  assign line_j     = (line_state == LS_J);
  assign eop        = eop_q;
  assign eop_err    = eop_err_q;
  assign usb_reset  = usb_reset_q;

  // Pins enter at bit 0 and leave at the top bit, SYNC_STAGES edges later.
  always_comb begin
    dp_sync_d = {dp_sync_q[SYNC_STAGES-2:0], d_plus};
    dm_sync_d = {dm_sync_q[SYNC_STAGES-2:0], d_minus};
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    eop_d       = 1'b0;
    eop_err_d   = 1'b0;
    usb_reset_d = usb_reset_q;

    unique case (state_q)
      IDLE: begin
        usb_reset_d = 1'b0;
        if (se0) begin
          state_d = SE0_CNT;
          cnt_d   = CNT_ONE;
        end
      end

      SE0_CNT: begin
        if (se0) begin
          cnt_d       = (cnt_q == RESET_C) ? cnt_q : cnt_q + CNT_ONE;
          usb_reset_d = (cnt_d == RESET_C);
        end else begin
          state_d     = IDLE;
          cnt_d       = '0;
          usb_reset_d = 1'b0;
          // Leaving a bus reset is silent; otherwise a long enough SE0 decides the pulse.
          if (!usb_reset_q && cnt_q >= SE0_MIN_C) begin
            if (!line_j) begin
              eop_err_d = 1'b1;
            end else if (J_MIN == 1) begin
              eop_d = 1'b1;
            end else begin
              state_d = J_CNT;
              cnt_d   = CNT_ONE;
            end
          end
        end
      end

      J_CNT: begin
        if (line_j) begin
          if (32'(cnt_q) >= J_MIN - 1) begin
            eop_d   = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          // An SE0 here only ends this EOP; the next SE0 period starts from IDLE.
          eop_err_d = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    if (!n_rst) begin
      // NOTE: synchronizers reset to the idle J level so no phantom SE0 follows reset.
      dp_sync_q   <= '1;
      dm_sync_q   <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      eop_q       <= 1'b0;
      eop_err_q   <= 1'b0;
      usb_reset_q <= 1'b0;
    end else begin
      dp_sync_q   <= dp_sync_d;
      dm_sync_q   <= dm_sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      eop_q       <= eop_d;
      eop_err_q   <= eop_err_d;
      usb_reset_q <= usb_reset_d;
    end
  end

endmodule
